trap_controller: RTL and testbench
==================================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_IRQ, default 2: number of interrupt channels, legal range 1..18.
REQ-003 Parameter TRAP_PC, default 0: reset value of mtvec.
REQ-004 clk_i  in  1  clock; all state SHALL change on its rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 irq_i  in  NUM_IRQ  level interrupt requests; ch0=timer (MTI), ch1=external (MEI), chN>=2=platform.
REQ-007 irq_en_o  out  NUM_IRQ  per-channel enable, equal to mstatus.MIE AND mie bit of that channel.
REQ-008 boundary_i  in  1  CPU is at the restartable point of an instruction, before any memory side effect.
REQ-009 pc_i  in  32  address of the instruction at the boundary.
REQ-010 trap_valid_o  out  1  trap request to the CPU; trap_pc_o  out  32  target address.
REQ-011 trap_ack_i  in  1  CPU has loaded trap_pc_o.
REQ-012 mret_i  in  1  single-cycle MRET execute pulse; ret_pc_o  out  32  equals mepc at all times.
REQ-013 csr_en_i 1, csr_addr_i 12, csr_op_i 2 (01=write, 10=set, 11=clear), csr_wdata_i 32  all in; csr_rdata_o 32, csr_ill_o 1  both out.

Function
REQ-014 Channel bit map SHALL be: ch0 -> bit 7, ch1 -> bit 11, chN>=2 -> bit 16+(N-2); the same bit is used in mie, in mip, and as the cause code.
REQ-015 Implemented CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] read 2'b11), mie 0x304, mtvec 0x305, mepc 0x341 (bits[1:0] read 0), mcause 0x342, mip 0x344 (read-only, mirrors irq_i).
REQ-016 csr_rdata_o SHALL be combinational, giving the value before any write in the same cycle. Writes SHALL take effect at the clock edge.
REQ-017 Unimplemented mie bits and mip writes SHALL be ignored. An unmapped address SHALL assert csr_ill_o combinationally, read 0, and cause no write.
REQ-018 An interrupt is taken when: boundary_i=1, state=IDLE, and (irq_i AND mie) is nonzero with mstatus.MIE=1.
REQ-019 Priority SHALL be ch1 > ch0 > ch2 > ch3 > ... (ascending index).
REQ-020 On the taking edge: mepc<=pc_i; mcause<={1'b1, code}; MPIE<=MIE; MIE<=0; state IDLE->PENDING.
REQ-021 In PENDING: trap_valid_o=1; trap_pc_o is held stable; boundary_i is ignored. trap_ack_i returns the state to IDLE on the next edge.
REQ-022 trap_valid_o SHALL be registered, rising exactly one cycle after the taking edge, i.e. latency 1.
REQ-023 On mret_i: MIE<=MPIE; MPIE<=1.
REQ-024 When an interrupt is taken in the same cycle as mret_i or a CSR write, the trap SHALL win and the other operation SHALL be dropped, because the instruction restarts.
REQ-025 A trap_ack_i received in IDLE SHALL be ignored.

Reset
REQ-026 Reset SHALL set: mstatus.MIE=0, MPIE=0, mie=0, mepc=0, mcause=0, mtvec=TRAP_PC, state=IDLE, trap_valid_o=0.
REQ-027 Reset in PENDING SHALL drop the request with no acknowledge.

Configuration
REQ-028 Macro TRAP_VECTORED_EN. When defined: mtvec[1:0] is writable, and mode 01 gives trap_pc_o = {mtvec[31:2],2'b00} + 4*code.
REQ-029 When TRAP_VECTORED_EN is undefined: mtvec[1:0] reads 0, and trap_pc_o = {mtvec[31:2],2'b00}.

Structure
REQ-030 Package trap_pkg SHALL hold: CSR address constants, the csr_op encodings, the channel-to-bit function, the mcause interrupt flag, and the IDLE/PENDING state enum.
REQ-031 Sub-module trap_prio_enc SHALL be combinational. It takes the masked pending vector and returns a valid flag and the cause code.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- mie=0x880, MIE=1, irq_i=2'b11, boundary with pc_i=0x100 -> mcause=0x8000000B, mepc=0x100, trap_valid_o=1 next cycle, MIE=0, MPIE=1.
- Ack, then mret_i -> MIE=1, ret_pc_o=0x100.
- trap_valid_o high for 3 cycles while boundary_i pulses -> no second capture, mepc unchanged.
- TRAP_VECTORED_EN, mtvec=0x201, timer taken -> trap_pc_o=0x21C. Without the macro -> 0x200.
- CSR set mie 0x80 in the same cycle an interrupt is taken -> mie unchanged.
- NUM_IRQ=4, ch3 only -> mcause=0x80000011. Reading address 0x7C0 -> csr_ill_o=1, rdata=0.
- rst_i in PENDING -> trap_valid_o=0 next cycle, mtvec=TRAP_PC.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller: CSR map, CSR op
// encodings, interrupt channel to mip/mie bit mapping and FSM state type.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [31:0] MCAUSE_IRQ = 32'h8000_0000;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } trap_state_e;

  // ch0 = MTI (7), ch1 = MEI (11), platform channels from bit 16 upward
  function automatic logic [4:0] chan_bit(input int ch);
    if (ch == 0)
      return 5'd7;
    else if (ch == 1)
      return 5'd11;
    else
      return 5'(16 + ch - 2);
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder over the masked pending vector.
// Order: ch1 first, then ch0, ch2, ch3 ... by ascending index.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 2
) (
  input  logic [NUM_IRQ-1:0] pend,
  output logic               valid,
  output logic [4:0]         code
);

  always_comb begin
    valid = |pend;
    code  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) code = chan_bit(i);
    end
    // MEI overrides the ascending scan
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (i == 1 && pend[i]) code = chan_bit(1);
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode interrupt trap controller with minimal CSR file.
// Optional macro TRAP_VECTORED_EN enables vectored mtvec mode (mode 01).
module trap_controller
  import trap_pkg::*;
#(
  parameter int          NUM_IRQ = 2,
  parameter logic [31:0] TRAP_PC = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] irq_en_o,
  input  logic               boundary_i,
  input  logic [31:0]        pc_i,
  output logic               trap_valid_o,
  output logic [31:0]        trap_pc_o,
  input  logic               trap_ack_i,
  input  logic               mret_i,
  output logic [31:0]        ret_pc_o,
  input  logic               csr_en_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [1:0]         csr_op_i,
  input  logic [31:0]        csr_wdata_i,
  output logic [31:0]        csr_rdata_o,
  output logic               csr_ill_o
);

  trap_state_e state_q, state_d;

  logic               mstatus_mie, mstatus_mpie;
  logic [31:0]        mie_q, mepc_q, mcause_q, mtvec_q, trap_pc_q;
  logic [31:0]        mie_mask, mip;
  logic [NUM_IRQ-1:0] pend;
  logic               pend_valid;
  logic [4:0]         pend_code;
  logic               take;
  logic               csr_we;
  logic [31:0]        csr_new;
  logic [31:0]        trap_base, trap_target;

  always_comb begin
    mie_mask = '0;
    mip      = '0;
    pend     = '0;
    irq_en_o = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      mie_mask[chan_bit(i)] = 1'b1;
      mip[chan_bit(i)]      = irq_i[i];
      pend[i]               = irq_i[i] & mie_q[chan_bit(i)];
      irq_en_o[i]           = mstatus_mie & mie_q[chan_bit(i)];
    end
  end

  trap_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .pend  (pend),
    .valid (pend_valid),
    .code  (pend_code)
  );

  assign take = boundary_i && (state_q == IDLE) && mstatus_mie && pend_valid;

  always_comb begin
    csr_rdata_o = '0;
    csr_ill_o   = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[12:11] = 2'b11;
        csr_rdata_o[7]     = mstatus_mpie;
        csr_rdata_o[3]     = mstatus_mie;
      end
      CSR_MIE:    csr_rdata_o = mie_q;
      CSR_MTVEC:  csr_rdata_o = mtvec_q;
      CSR_MEPC:   csr_rdata_o = mepc_q;
      CSR_MCAUSE: csr_rdata_o = mcause_q;
      CSR_MIP:    csr_rdata_o = mip;
      default:    csr_ill_o   = csr_en_i;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      CSR_OP_WRITE: csr_new = csr_wdata_i;
      CSR_OP_SET:   csr_new = csr_rdata_o | csr_wdata_i;
      CSR_OP_CLEAR: csr_new = csr_rdata_o & ~csr_wdata_i;
      default:      csr_new = csr_rdata_o;
    endcase
  end

  assign csr_we = csr_en_i && (csr_op_i != 2'b00) && !csr_ill_o;

  assign trap_base = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign trap_target = (mtvec_q[1:0] == 2'b01) ?
                       trap_base + {25'b0, pend_code, 2'b00} : trap_base;
`else
  assign trap_target = trap_base;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      trap_pc_q    <= '0;
`ifdef TRAP_VECTORED_EN
      mtvec_q      <= TRAP_PC;
`else
      mtvec_q      <= {TRAP_PC[31:2], 2'b00};
`endif
    end else if (take) begin
      // The interrupted instruction restarts, so a same-cycle CSR write or MRET is dropped
      mepc_q       <= {pc_i[31:2], 2'b00};
      mcause_q     <= MCAUSE_IRQ | {27'b0, pend_code};
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      trap_pc_q    <= trap_target;
    end else begin
      if (csr_we) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mstatus_mie  <= csr_new[3];
            mstatus_mpie <= csr_new[7];
          end
          CSR_MIE:    mie_q    <= csr_new & mie_mask;
`ifdef TRAP_VECTORED_EN
          CSR_MTVEC:  mtvec_q  <= csr_new;
`else
          CSR_MTVEC:  mtvec_q  <= {csr_new[31:2], 2'b00};
`endif
          CSR_MEPC:   mepc_q   <= {csr_new[31:2], 2'b00};
          CSR_MCAUSE: mcause_q <= csr_new;
          default: ;
        endcase
      end
      if (mret_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take)       state_d = PENDING;
      PENDING: if (trap_ack_i) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  assign trap_valid_o = (state_q == PENDING);
  assign trap_pc_o    = trap_pc_q;
  assign ret_pc_o     = mepc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller (NUM_IRQ=4, TRAP_PC=0x400).
module tb_trap_controller;
  import trap_pkg::*;

  localparam int          NIRQ  = 4;
  localparam logic [31:0] TPC   = 32'h0000_0400;
`ifdef TRAP_VECTORED_EN
  localparam bit          VEC   = 1'b1;
`else
  localparam bit          VEC   = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] irq, irq_en;
  logic            boundary;
  logic [31:0]     pc;
  logic            trap_valid;
  logic [31:0]     trap_pc;
  logic            trap_ack;
  logic            mret;
  logic [31:0]     ret_pc;
  logic            csr_en;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [31:0]     csr_wdata, csr_rdata;
  logic            csr_ill;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;
  logic        ill;

  trap_controller #(.NUM_IRQ(NIRQ), .TRAP_PC(TPC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_i        (irq),
    .irq_en_o     (irq_en),
    .boundary_i   (boundary),
    .pc_i         (pc),
    .trap_valid_o (trap_valid),
    .trap_pc_o    (trap_pc),
    .trap_ack_i   (trap_ack),
    .mret_i       (mret),
    .ret_pc_o     (ret_pc),
    .csr_en_i     (csr_en),
    .csr_addr_i   (csr_addr),
    .csr_op_i     (csr_op),
    .csr_wdata_i  (csr_wdata),
    .csr_rdata_o  (csr_rdata),
    .csr_ill_o    (csr_ill)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_en = 1'b1; csr_addr = a; csr_op = op; csr_wdata = d;
    tick();
    csr_en = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] val, output logic il);
    csr_en = 1'b1; csr_addr = a; csr_op = 2'b00;
    #1;
    val = csr_rdata;
    il  = csr_ill;
    csr_en = 1'b0;
  endtask

  task automatic take_irq(input logic [NIRQ-1:0] lines, input logic [31:0] at_pc);
    irq = lines; boundary = 1'b1; pc = at_pc;
    tick();
    boundary = 1'b0;
  endtask

  task automatic ack_and_return();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0; irq = '0; mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; boundary = 1'b0; pc = '0; trap_ack = 1'b0; mret = 1'b0;
    csr_en = 1'b0; csr_addr = '0; csr_op = 2'b00; csr_wdata = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", 32'(trap_valid), 32'h0);
    rd(CSR_MSTATUS, v, ill); chk("rst_mstatus", v, 32'h0000_1800);
    rd(CSR_MTVEC,   v, ill); chk("rst_mtvec",   v, TPC);
    rd(CSR_MIE,     v, ill); chk("rst_mie",     v, 32'h0);
    rd(CSR_MEPC,    v, ill); chk("rst_mepc",    v, 32'h0);
    rd(CSR_MCAUSE,  v, ill); chk("rst_mcause",  v, 32'h0);

    csr(CSR_MIE, CSR_OP_WRITE, 32'h880);
    csr(CSR_MSTATUS, CSR_OP_SET, 32'h8);
    chk("irq_en", 32'(irq_en), 32'h3);

    // MEI beats MTI
    take_irq(4'b0011, 32'h100);
    chk("take_valid", 32'(trap_valid), 32'h1);
    rd(CSR_MCAUSE,  v, ill); chk("take_mcause",  v, 32'h8000_000B);
    rd(CSR_MEPC,    v, ill); chk("take_mepc",    v, 32'h100);
    rd(CSR_MSTATUS, v, ill); chk("take_mstatus", v, 32'h0000_1880);
    chk("take_trap_pc", trap_pc, 32'h400);

    boundary = 1'b1; pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(trap_valid), 32'h1);
    end
    boundary = 1'b0;
    rd(CSR_MEPC, v, ill); chk("hold_mepc", v, 32'h100);

    ack_and_return();
    chk("ack_valid", 32'(trap_valid), 32'h0);
    rd(CSR_MSTATUS, v, ill); chk("mret_mstatus", v, 32'h0000_1888);
    chk("mret_ret_pc", ret_pc, 32'h100);

    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    chk("idle_ack", 32'(trap_valid), 32'h0);

    csr(CSR_MTVEC, CSR_OP_WRITE, 32'h201);
    rd(CSR_MTVEC, v, ill); chk("mtvec_rd", v, VEC ? 32'h201 : 32'h200);
    take_irq(4'b0001, 32'h140);
    rd(CSR_MCAUSE, v, ill); chk("mti_mcause", v, 32'h8000_0007);
    chk("mti_trap_pc", trap_pc, VEC ? 32'h21C : 32'h200);
    ack_and_return();

    // CSR set and MRET in the taking cycle are both dropped
    csr(CSR_MIE, CSR_OP_WRITE, 32'h800);
    irq = 4'b0010; boundary = 1'b1; pc = 32'h180;
    csr_en = 1'b1; csr_addr = CSR_MIE; csr_op = CSR_OP_SET; csr_wdata = 32'h80; mret = 1'b1;
    tick();
    boundary = 1'b0; csr_en = 1'b0; csr_op = 2'b00; csr_wdata = '0; mret = 1'b0;
    rd(CSR_MIE,     v, ill); chk("race_mie",     v, 32'h800);
    rd(CSR_MSTATUS, v, ill); chk("race_mstatus", v, 32'h0000_1880);
    rd(CSR_MEPC,    v, ill); chk("race_mepc",    v, 32'h180);
    ack_and_return();

    csr(CSR_MIE, CSR_OP_WRITE, 32'hFFFF_FFFF);
    rd(CSR_MIE, v, ill); chk("mie_mask", v, 32'h0003_0880);
    irq = 4'b1010;
    rd(CSR_MIP, v, ill); chk("mip_rd", v, 32'h0002_0800);
    csr(CSR_MIP, CSR_OP_WRITE, 32'h0);
    rd(CSR_MIP, v, ill); chk("mip_ro", v, 32'h0002_0800);
    irq = '0;

    take_irq(4'b1000, 32'h1C0);
    rd(CSR_MCAUSE, v, ill); chk("ch3_mcause", v, 32'h8000_0011);
    ack_and_return();
    take_irq(4'b1100, 32'h1C4);
    rd(CSR_MCAUSE, v, ill); chk("ch2_mcause", v, 32'h8000_0010);
    ack_and_return();
    take_irq(4'b1101, 32'h1C8);
    rd(CSR_MCAUSE, v, ill); chk("ch0_mcause", v, 32'h8000_0007);
    ack_and_return();

    rd(12'h7C0, v, ill);
    chk("ill_flag",  32'(ill), 32'h1);
    chk("ill_rdata", v, 32'h0);
    rd(CSR_MIE, v, ill); chk("legal_ill", 32'(ill), 32'h0);

    take_irq(4'b0010, 32'h1D0);
    chk("pre_rst_valid", 32'(trap_valid), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_pend_valid", 32'(trap_valid), 32'h0);
    rd(CSR_MTVEC,   v, ill); chk("rst_pend_mtvec",   v, TPC);
    rd(CSR_MSTATUS, v, ill); chk("rst_pend_mstatus", v, 32'h0000_1800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
